y_response_monitor: RTL

//  Response-side counterpart to the stimulus driver: consumes the 82-bit DUT output

---
 rtl/y_response_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/y_response_monitor.sv
// Response monitor: folds sampled DUT outputs into a MISR, counts them, buffers raw
// samples in a small FIFO, and compares the final signature against a golden value.
module y_response_monitor #(
  parameter int unsigned    Y_W   = 82,
  parameter logic [Y_W-1:0] POLY  = Y_W'(3),
  parameter int unsigned    DEPTH = 4,
  parameter int unsigned    CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Y_W-1:0]   y_in,
  input  logic             y_valid,
  input  logic             finish,
  input  logic [Y_W-1:0]   exp_sig,
  output logic [Y_W-1:0]   rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [Y_W-1:0]   signature,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [Y_W-1:0]   sig_q, sig_d;
  logic [Y_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [Y_W-1:0]   mem_q [DEPTH];
  logic [Y_W-1:0]   mem_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             pop;
  logic             full;
  logic             push_ok;

  // Next-state logic: start dominates finish and sampling in the same cycle.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    mem_d   = mem_q;
    ovf_d   = ovf_q;
    pass_d  = pass_q;
    accept  = (state_q == RUN) && y_valid;
    pop     = (occ_q != '0) && rd_ready;
    full    = (occ_q == OCC_W'(DEPTH));
    push_ok = accept && (!full || pop);

    if (start) begin
      state_d = RUN;
      sig_d   = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      occ_d   = '0;
      ovf_d   = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (finish) begin
            state_d = CHECK;
            exp_d   = exp_sig;
          end
        end
        CHECK: begin
          state_d = DONE;
          pass_d  = (sig_q == exp_q);
        end
        default: ;
      endcase

      if (accept) begin
        sig_d = {sig_q[Y_W-2:0], 1'b0} ^ (sig_q[Y_W-1] ? POLY : '0) ^ y_in;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (!push_ok) ovf_d = 1'b1;
      end

      if (push_ok) begin
        mem_d[wr_q] = y_in;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);

      case ({push_ok, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data   = mem_q[rd_q];
  assign rd_valid  = (occ_q != '0);
  assign signature = sig_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule
